// File: rtl/clock_div_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_monitor_pkg
// Shared definitions for the divided-clock monitor.
//   state_e     : monitor FSM state encoding (also exported on the debug port)
//   MATCH_CNT_W : width of the consecutive-match counter used to qualify lock
// -----------------------------------------------------------------------------
package clock_div_monitor_pkg;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,   // waiting for the first edge after reset or a stall
        MEASURE = 2'd1,   // measuring periods, counting consecutive matches
        LOCKED  = 2'd2    // ratio verified, watching for mismatch or stall
    } state_e;

    localparam int MATCH_CNT_W = 4;

endpackage

// File: rtl/clock_div_monitor_edge_sync.sv
// -----------------------------------------------------------------------------
// clock_div_monitor_edge_sync
// Samples the observed divided clock into the clk_i domain and produces a
// registered one-cycle strobe for each rising edge.
//
// Build option: CLOCK_DIV_MONITOR_SYNC_EN
//   defined   -> two-flop synchronizer (asynchronous sources), 3-cycle latency
//   undefined -> single sampling flop (clk_i-synchronous sources), 2-cycle latency
// Latency counts from the first clk_i posedge at which i_div_clk is high to
// the cycle in which o_edge is high.
//
// Ports:
//   i_clk     in   reference clock, posedge
//   i_rst_n   in   synchronous active-low reset
//   i_div_clk in   divided clock under observation
//   o_edge    out  registered rising-edge strobe, one cycle wide
// -----------------------------------------------------------------------------
module clock_div_monitor_edge_sync
    import clock_div_monitor_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_div_clk,
    output logic o_edge
);

    logic w_sample;
    logic r_prev;
    logic r_edge;

`ifdef CLOCK_DIV_MONITOR_SYNC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_div_clk;
            r_sync <= r_meta;
        end
    end

    assign w_sample = r_sync;
`else
    logic r_samp;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_samp <= 1'b0;
        end else begin
            r_samp <= i_div_clk;
        end
    end

    assign w_sample = r_samp;
`endif

    // Rising edge = current sample high, previous sample low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_prev <= w_sample;
            r_edge <= w_sample & ~r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/clock_div_monitor.sv
// -----------------------------------------------------------------------------
// clock_div_monitor
// Watches a divided clock from the clk_i side: strobes each rising edge,
// measures the period in clk_i cycles, declares lock after LOCK_CNT
// consecutive periods within EXP_DIV +/- TOL, and raises a sticky error on
// any mismatch or when the divided clock stops toggling.
//
// Build option: CLOCK_DIV_MONITOR_SYNC_EN (see clock_div_monitor_edge_sync);
// it only changes edge latency, never the measured periods.
//
// Ports:
//   clk_i       in   reference clock, all logic on posedge
//   rst_        in   synchronous active-low reset
//   div_clk_i   in   divided clock under observation
//   edge_o      out  one-cycle strobe per rising edge (usable as clock enable)
//   period_o    out  last measured period, clk_i cycles (CNT_W bits)
//   valid_o     out  one-cycle pulse when period_o updates
//   locked_o    out  divide ratio verified
//   err_o       out  sticky mismatch/stall flag, cleared only by reset
//   o_dbg_state out  current FSM state
//
// valid_o semantics: a pure pulse with no back-pressure. It is high for
// exactly the one cycle in which period_o holds a freshly measured value;
// consumers that miss it simply see the value persist until the next edge.
// -----------------------------------------------------------------------------
module clock_div_monitor
    import clock_div_monitor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int EXP_DIV  = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_i,
    input  logic             rst_,
    input  logic             div_clk_i,
    output logic             edge_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o,
    output state_e           o_dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Lower bound clamps at zero so a large TOL cannot wrap negative.
    localparam int LO_INT = (EXP_DIV > TOL) ? (EXP_DIV - TOL) : 0;
    localparam int HI_INT = EXP_DIV + TOL;
    // Bounds carried at CNT_W+1 bits so EXP_DIV+TOL does not wrap.
    localparam logic [CNT_W:0] LO_BOUND = (CNT_W+1)'(LO_INT);
    localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(HI_INT);
    localparam logic [MATCH_CNT_W-1:0] LOCK_TGT = MATCH_CNT_W'(LOCK_CNT);

    logic                   w_edge;
    logic [CNT_W-1:0]       w_period;
    logic [CNT_W:0]         w_period_ext;
    logic                   w_match;
    logic                   w_cnt_sat;
    logic [MATCH_CNT_W-1:0] w_mc_next;

    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [MATCH_CNT_W-1:0] r_mc;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_err;

    clock_div_monitor_edge_sync u_edge_sync (
        .i_clk     (clk_i),
        .i_rst_n   (rst_),
        .i_div_clk (div_clk_i),
        .o_edge    (w_edge)
    );

    // Period is cnt+1 at the edge cycle; a saturated count wraps to 0 here,
    // which then falls outside the match window.
    assign w_period     = r_cnt + CNT_W'(1);
    assign w_period_ext = {1'b0, w_period};
    assign w_match      = (w_period_ext >= LO_BOUND) && (w_period_ext <= HI_BOUND);
    assign w_cnt_sat    = (r_cnt == CNT_MAX);
    assign w_mc_next    = r_mc + MATCH_CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_) begin
            r_state  <= SEEK;
            r_cnt    <= '0;
            r_mc     <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Free-running period counter, restarted by every edge.
            if (w_edge) begin
                r_cnt <= '0;
            end else if (!w_cnt_sat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // An edge wins over saturation in the same cycle.
            if (w_edge) begin
                case (r_state)
                    SEEK: begin
                        // First edge only opens a measurement window.
                        r_state <= MEASURE;
                        r_mc    <= '0;
                    end
                    MEASURE: begin
                        r_period <= w_period;
                        r_valid  <= 1'b1;
                        if (w_match) begin
                            if (w_mc_next == LOCK_TGT) begin
                                r_locked <= 1'b1;
                                r_state  <= LOCKED;
                                r_mc     <= '0;
                            end else begin
                                r_mc <= w_mc_next;
                            end
                        end else begin
                            r_mc  <= '0;
                            r_err <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        r_period <= w_period;
                        r_valid  <= 1'b1;
                        if (!w_match) begin
                            r_locked <= 1'b0;
                            r_err    <= 1'b1;
                            r_mc     <= '0;
                            r_state  <= MEASURE;
                        end
                    end
                    default: begin
                        r_state <= SEEK;
                    end
                endcase
            end else if (w_cnt_sat && (r_state != SEEK)) begin
                // Counter ran out with no edge: divided clock has stopped.
                // period_o keeps the last good measurement.
                r_err    <= 1'b1;
                r_locked <= 1'b0;
                r_mc     <= '0;
                r_state  <= SEEK;
            end
        end
    end

    assign edge_o      = w_edge;
    assign period_o    = r_period;
    assign valid_o     = r_valid;
    assign locked_o    = r_locked;
    assign err_o       = r_err;
    assign o_dbg_state = r_state;

endmodule
